// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with fill count, almost flags, sticky error flags,
// synchronous flush and selectable first-word-fall-through read.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  assign count        = cnt;
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)
        cnt <= cnt + 1'b1;
      else if (rd_acc && !wr_acc)
        cnt <= cnt - 1'b1;
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush)
      mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          dout_q <= '0;
        else if (flush)
          dout_q <= '0;
        else if (rd_acc)
          dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Single-clock, parametrised FIFO. It succeeds the team's dual-clock FIFO for same-domain buffering. It adds a fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Storage is a register/RAM array of DEPTH = 2**ADDR_WIDTH entries, read and written from one clock domain.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16)
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL; legal range AE_LEVEL < AF_LEVEL <= DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0 <= AE_LEVEL < AF_LEVEL
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear, highest priority
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read request
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, data_out = 0. Memory contents are not cleared.
- Accept rules:
  - Write is accepted iff w_en && !full.
  - Read is accepted iff r_en && !empty.
  - Both rules use the flag values present before the edge.
  - A write to a full FIFO is rejected, even if a read occurs in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read: rd_ptr increments.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 with no special case.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous accepted read and write, including at count == 1 and count == DEPTH-1.
- Flags: full, empty, almost_full, almost_empty are pure decodes of the registered count. There is no combinational path from w_en, r_en or data_in to any flag.
- Standard mode (FWFT = 0):
  - data_out is registered. On the edge of an accepted read, data_out <= mem[rd_ptr], valid immediately after that edge (1-cycle read latency).
  - data_out holds its value when no read is accepted.
- FWFT mode (FWFT = 1):
  - data_out = mem[rd_ptr] whenever empty == 0. The head word is visible before r_en is asserted.
  - A write into an empty FIFO is visible on data_out right after that write edge, when empty falls.
  - An accepted read advances to the next word after the edge.
  - data_out is don't-care while empty == 1.
- overflow: set on any edge with w_en && full && !flush.
- underflow: set on any edge with r_en && empty && !flush.
- Both error flags stay set until flush or reset. A rejected request changes no other state.
- flush (synchronous, overrides w_en and r_en in the same cycle):
  - Pointers and count go to 0; overflow and underflow are cleared.
  - data_out goes to 0 in standard mode.
  - Flags reach their reset values after the edge.
- Reset asserted mid-operation: all state returns to reset values immediately. The first access after rst_n deasserts behaves as on an empty FIFO.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with no reads -> count increments 1..16. almost_full rises on the edge where count reaches 14. full = 1 at count 16. empty = 0 from the first write.
- From full, a 17th write of 0xAA -> rejected, count stays 16, overflow = 1 and stays 1. Then 16 reads return 0x00..0x0F in order; 0xAA never appears.
- Continuous simultaneous write and read at count 8, 40 cycles -> count stays 8, pointers wrap at least twice, read data order matches a scoreboard.
- From empty, r_en = 1 -> underflow = 1, data_out unchanged (standard mode), count stays 0. Then flush = 1 for one cycle -> underflow = 0, empty = 1.
- FWFT = 1: write 0x5C into empty -> on the next cycle data_out = 0x5C with r_en = 0. Assert r_en -> empty returns to 1 after the edge.
- Fill to count 10, assert rst_n = 0 asynchronously mid-cycle -> count = 0, empty = 1, flags cleared without waiting for clk. Write 0x33 and read it back -> 0x33.
